// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/subtract sequencer: one full-adder slice reused over WIDTH cycles,
// with a start/busy/done handshake and a result register kept separate from the shift register.
module serial_adder_ctrl #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             sub,
   input  logic             abort,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] Sum,
   output logic             Cout,
   output logic             Ovf
);

   localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] LastBit = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e             state_q, state_d;
   logic [WIDTH-1:0]   opa_q, opa_d;
   logic [WIDTH-1:0]   opb_q, opb_d;
   logic [WIDTH-1:0]   sr_q, sr_d;
   logic [WIDTH-1:0]   sum_q, sum_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               carry_q, carry_d;
   logic               cin_msb_q, cin_msb_d;
   logic               cout_q, cout_d;
   logic               ovf_q, ovf_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               s_bit, c_bit;

   // The single shared bit slice
   assign s_bit = opa_q[0] ^ opb_q[0] ^ carry_q;
   assign c_bit = (opa_q[0] & opb_q[0]) | (opa_q[0] & carry_q) | (opb_q[0] & carry_q);

   always_comb begin
      state_d   = state_q;
      opa_d     = opa_q;
      opb_d     = opb_q;
      sr_d      = sr_q;
      sum_d     = sum_q;
      cnt_d     = cnt_q;
      carry_d   = carry_q;
      cin_msb_d = cin_msb_q;
      cout_d    = cout_q;
      ovf_d     = ovf_q;
      done_d    = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               opa_d   = A;
               opb_d   = sub ? ~B : B;
               carry_d = sub;
               cnt_d   = '0;
               state_d = StRun;
            end
         end
         StRun: begin
            if (abort) begin
               state_d = StIdle;
            end else begin
               opa_d   = opa_q >> 1;
               opb_d   = opb_q >> 1;
               sr_d    = {s_bit, sr_q[WIDTH-1:1]};
               carry_d = c_bit;
               if (cnt_q == LastBit) begin
                  cin_msb_d = carry_q;
                  state_d   = StDone;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         StDone: begin
            done_d  = 1'b1;
            sum_d   = sr_q;
            cout_d  = carry_q;
            ovf_d   = carry_q ^ cin_msb_q;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
      busy_d = (state_d != StIdle);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         opa_q     <= '0;
         opb_q     <= '0;
         sr_q      <= '0;
         sum_q     <= '0;
         cnt_q     <= '0;
         carry_q   <= 1'b0;
         cin_msb_q <= 1'b0;
         cout_q    <= 1'b0;
         ovf_q     <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         opa_q     <= opa_d;
         opb_q     <= opb_d;
         sr_q      <= sr_d;
         sum_q     <= sum_d;
         cnt_q     <= cnt_d;
         carry_q   <= carry_d;
         cin_msb_q <= cin_msb_d;
         cout_q    <= cout_d;
         ovf_q     <= ovf_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign Sum  = sum_q;
   assign Cout = cout_q;
   assign Ovf  = ovf_q;

endmodule
